// File: rtl/gated_clk_ctrl_pkg.sv
// Shared types and defaults for the gated clock branch sequencer.
// State encoding is fixed because the gated-clock cell wrapper decodes it.
package gated_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int WAKE_CYC_DEF = 2;
    localparam int IDLE_CYC_DEF = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gated_clk_ctrl_if.sv
// Requester-side bundle of the gated clock sequencer: requests, acks and clock status.
// The master side is the requester group; the slave side is the sequencer.
interface gated_clk_ctrl_if #(
    parameter int N_REQ = 4
);
    logic             gate_en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             clken;
    logic             busy;

    modport master (
        output gate_en,
        output req,
        input  ack,
        input  clken,
        input  busy
    );

    modport slave (
        input  gate_en,
        input  req,
        output ack,
        output clken,
        output busy
    );
endinterface

// File: rtl/gated_clk_ctrl_dly_cnt.sv
// Loadable down-counter shared by the wake settle and idle hysteresis delays.
// Stops at zero so a stray decrement never wraps into a long delay.
module gclk_dly_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clkin) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/gated_clk_ctrl.sv
// Sequencer for one gated clock branch: request collection, wake settle, idle hysteresis.
// Optional on-time statistics counter enabled by defining CLK_GATE_STATS_EN.
//
// state   | meaning
// OFF     | clock gated, waiting for any request or gate_en=0
// WAKE    | clken high, waiting WAKE_CYC cycles for the branch to settle
// ON      | clock running and settled; acks follow requests
// HOLD    | no request; keep clock for IDLE_CYC cycles before gating
module gated_clk_ctrl
    import gated_clk_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WAKE_CYC = WAKE_CYC_DEF,
    parameter int IDLE_CYC = IDLE_CYC_DEF,
    parameter int CNT_W    = 4
`ifdef CLK_GATE_STATS_EN
    ,
    parameter int STAT_W   = 32
`endif
) (
    input  logic              clkin,
    input  logic              rst_n,
    gated_clk_ctrl_if.slave   bus
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] on_cnt
`endif
);
    state_t           state;
    logic             clken_q;
    logic             wake;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign wake = (|bus.req) | ~bus.gate_en;

    // WAKE decrements unconditionally: the settle delay always completes.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_OFF: begin
                if (wake) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(WAKE_CYC - 1);
                end
            end
            ST_WAKE: cnt_dec = 1'b1;
            ST_ON: begin
                if (!wake) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(IDLE_CYC - 1);
                end
            end
            ST_HOLD: cnt_dec = ~wake;
            default: cnt_dec = 1'b0;
        endcase
    end

    gclk_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            clken_q <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (wake) begin
                        state   <= ST_WAKE;
                        clken_q <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (cnt_zero)
                        state <= ST_ON;
                end
                ST_ON: begin
                    if (!wake)
                        state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (wake) begin
                        state <= ST_ON;
                    end else if (cnt_zero) begin
                        state   <= ST_OFF;
                        clken_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_OFF;
                    clken_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clken = clken_q;
    assign bus.busy  = (state != ST_OFF);
    assign bus.ack   = bus.req & {N_REQ{state == ST_ON}};

`ifdef CLK_GATE_STATS_EN
    always_ff @(posedge clkin) begin
        if (!rst_n || stat_clr)
            on_cnt <= '0;
        else if (clken_q && (on_cnt != {STAT_W{1'b1}}))
            on_cnt <= on_cnt + 1'b1;
    end
`endif
endmodule
